pipelined_hazard_ctrl: RTL and testbench

//   Hazard unit for the 5-stage pipeline; consumes the EXE- and MEM-stage destination fields of the ID/EXE and EXE/MEM registers.

---
 rtl/pipelined_hazard_ctrl_if.sv | 27 ++
 rtl/pipelined_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipelined_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_hazard_ctrl_if.sv
// Hazard-unit bundle: ID source fields, EXE/MEM destination fields, and the
// forwarding/stall/flush controls and perf counters returned to the pipeline.
interface pipelined_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       ID_rs, ID_rt;
  logic             ID_use_rs, ID_use_rt, ID_Branch_taken;
  logic             EXE_Wreg, EXE_Reg2reg;
  logic [4:0]       EXE_write_reg;
  logic             MEM_Wreg, MEM_Reg2reg;
  logic [4:0]       MEM_write_reg;
  logic [1:0]       FwdA, FwdB;
  logic             Stall, Bubble, Flush_IF;
  logic [CNT_W-1:0] Stall_cnt, Flush_cnt;

  modport master (
    output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_Branch_taken,
           EXE_Wreg, EXE_Reg2reg, EXE_write_reg,
           MEM_Wreg, MEM_Reg2reg, MEM_write_reg,
    input  FwdA, FwdB, Stall, Bubble, Flush_IF, Stall_cnt, Flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_Branch_taken,
           EXE_Wreg, EXE_Reg2reg, EXE_write_reg,
           MEM_Wreg, MEM_Reg2reg, MEM_write_reg,
    output FwdA, FwdB, Stall, Bubble, Flush_IF, Stall_cnt, Flush_cnt
  );
endinterface

// File: rtl/pipelined_hazard_ctrl.sv
// ID-stage hazard unit: per-operand forwarding selects, load-use / no-forward
// stall sequencing, branch flush, and saturating stall/flush counters.
module pipelined_hazard_ctrl_lane #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic       exe_wreg_i,
  input  logic       exe_reg2reg_i,
  input  logic [4:0] exe_wr_i,
  input  logic       mem_wreg_i,
  input  logic       mem_reg2reg_i,
  input  logic [4:0] mem_wr_i,
  output logic       match_e_o,
  output logic       match_m_o,
  output logic [1:0] fwd_o
);
  // $0 is hardwired zero, so it never creates a dependency
  assign match_e_o = exe_wreg_i & use_i & (exe_wr_i == src_i) & (src_i != 5'd0);
  assign match_m_o = mem_wreg_i & use_i & (mem_wr_i == src_i) & (src_i != 5'd0);

  always_comb begin
    fwd_o = 2'b00;
    if (FORWARD_EN) begin
      if (match_e_o && exe_reg2reg_i) fwd_o = 2'b01;
      else if (match_m_o)             fwd_o = mem_reg2reg_i ? 2'b10 : 2'b11;
    end
  end
endmodule

module pipelined_hazard_ctrl #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                   Clk,
  input  logic                   Clrn,
  pipelined_hazard_ctrl_if.slave hz
);
  localparam int NUM_SRC = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN, STALL} state_e;

  logic [NUM_SRC-1:0][4:0] src;
  logic [NUM_SRC-1:0]      use_src, match_e, match_m;
  logic [NUM_SRC-1:0][1:0] fwd;

  state_e     state_q, state_d;
  logic [1:0] stall_left_q, stall_left_d;
  logic [1:0] need;
  logic       stall, flush;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign src     = {hz.ID_rt, hz.ID_rs};
  assign use_src = {hz.ID_use_rt, hz.ID_use_rs};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    pipelined_hazard_ctrl_lane #(.FORWARD_EN(FORWARD_EN)) u_lane (
      .src_i        (src[g]),
      .use_i        (use_src[g]),
      .exe_wreg_i   (hz.EXE_Wreg),
      .exe_reg2reg_i(hz.EXE_Reg2reg),
      .exe_wr_i     (hz.EXE_write_reg),
      .mem_wreg_i   (hz.MEM_Wreg),
      .mem_reg2reg_i(hz.MEM_Reg2reg),
      .mem_wr_i     (hz.MEM_write_reg),
      .match_e_o    (match_e[g]),
      .match_m_o    (match_m[g]),
      .fwd_o        (fwd[g])
    );
  end

  // Without forwarding an EXE producer needs two cycles to reach the regfile
  always_comb begin
    need = 2'd0;
    if (FORWARD_EN) begin
      if ((|match_e) && !hz.EXE_Reg2reg) need = 2'd1;
    end else begin
      if (|match_e)      need = 2'd2;
      else if (|match_m) need = 2'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    stall        = 1'b0;
    flush        = 1'b0;
    case (state_q)
      RUN: begin
        if (need == 2'd0) begin
          flush = hz.ID_Branch_taken;
        end else begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_d      = STALL;
            stall_left_d = 2'd1;
          end
        end
      end
      STALL: begin
        stall        = 1'b1;
        stall_left_d = stall_left_q - 2'd1;
        if (stall_left_q <= 2'd1) begin
          state_d      = RUN;
          stall_left_d = 2'd0;
        end
      end
      default: begin
        state_d      = RUN;
        stall_left_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q      <= RUN;
      stall_left_q <= 2'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hz.FwdA      = fwd[0];
  assign hz.FwdB      = fwd[1];
  assign hz.Stall     = stall;
  assign hz.Bubble    = stall;
  assign hz.Flush_IF  = flush;
  assign hz.Stall_cnt = stall_cnt_q;
  assign hz.Flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipelined_hazard_ctrl.sv
// Bench for pipelined_hazard_ctrl: forwarding (16-bit counters), no-forward,
// and forwarding with 2-bit counters, all sharing one stimulus stream.
module tb_pipelined_hazard_ctrl;
  logic Clk = 1'b0;
  logic Clrn = 1'b0;
  always #5 Clk = ~Clk;

  logic [4:0] rs, rt, ewr, mwr;
  logic urs, urt, br, ew, er, mw, mr;

  pipelined_hazard_ctrl_if #(.CNT_W(16)) if_f1 ();
  pipelined_hazard_ctrl_if #(.CNT_W(16)) if_f0 ();
  pipelined_hazard_ctrl_if #(.CNT_W(2))  if_sat ();

  `define HZ_DRIVE(IFN) \
    assign IFN.ID_rs = rs; assign IFN.ID_rt = rt; \
    assign IFN.ID_use_rs = urs; assign IFN.ID_use_rt = urt; assign IFN.ID_Branch_taken = br; \
    assign IFN.EXE_Wreg = ew; assign IFN.EXE_Reg2reg = er; assign IFN.EXE_write_reg = ewr; \
    assign IFN.MEM_Wreg = mw; assign IFN.MEM_Reg2reg = mr; assign IFN.MEM_write_reg = mwr;
  `HZ_DRIVE(if_f1)
  `HZ_DRIVE(if_f0)
  `HZ_DRIVE(if_sat)

  pipelined_hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(16)) u_f1  (.Clk(Clk), .Clrn(Clrn), .hz(if_f1));
  pipelined_hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(16)) u_f0  (.Clk(Clk), .Clrn(Clrn), .hz(if_f0));
  pipelined_hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(2))  u_sat (.Clk(Clk), .Clrn(Clrn), .hz(if_sat));

  logic [1:0] dfa[3], dfb[3];
  logic       dst[3], dbu[3], dfl[3];
  int         dsc[3], dfc[3];
  assign dfa[0] = if_f1.FwdA;  assign dfa[1] = if_f0.FwdA;  assign dfa[2] = if_sat.FwdA;
  assign dfb[0] = if_f1.FwdB;  assign dfb[1] = if_f0.FwdB;  assign dfb[2] = if_sat.FwdB;
  assign dst[0] = if_f1.Stall; assign dst[1] = if_f0.Stall; assign dst[2] = if_sat.Stall;
  assign dbu[0] = if_f1.Bubble; assign dbu[1] = if_f0.Bubble; assign dbu[2] = if_sat.Bubble;
  assign dfl[0] = if_f1.Flush_IF; assign dfl[1] = if_f0.Flush_IF; assign dfl[2] = if_sat.Flush_IF;
  assign dsc[0] = int'(if_f1.Stall_cnt); assign dsc[1] = int'(if_f0.Stall_cnt); assign dsc[2] = int'(if_sat.Stall_cnt);
  assign dfc[0] = int'(if_f1.Flush_cnt); assign dfc[1] = int'(if_f0.Flush_cnt); assign dfc[2] = int'(if_sat.Flush_cnt);

  int n_pass = 0, n_tot = 0;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference model: a pending-stall count per instance plus plain counters
  bit fen[3]  = '{1'b1, 1'b0, 1'b1};
  int cmax[3] = '{65535, 65535, 3};
  int pend[3], scnt[3], fcnt[3];

  function automatic int mfwd(bit f, logic [4:0] r, logic u);
    if (!f || !u || r == 5'd0) return 0;
    if (ew && ewr == r && er) return 1;
    if (mw && mwr == r) return mr ? 2 : 3;
    return 0;
  endfunction

  function automatic int mneed(bit f);
    bit he, hm;
    he = (urs && rs != 0 && ew && ewr == rs) || (urt && rt != 0 && ew && ewr == rt);
    hm = (urs && rs != 0 && mw && mwr == rs) || (urt && rt != 0 && mw && mwr == rt);
    if (f) return (he && !er) ? 1 : 0;
    return he ? 2 : (hm ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin pend[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
  endtask

  task automatic clear_in();
    rs = 0; rt = 0; urs = 0; urt = 0; br = 0;
    ew = 0; er = 0; ewr = 0; mw = 0; mr = 0; mwr = 0;
  endtask

  // Compare all instances against the model, then advance one clock
  task automatic step(string nm);
    int nd, st, fl;
    #1;
    for (int k = 0; k < 3; k++) begin
      nd = mneed(fen[k]);
      st = (pend[k] > 0 || nd > 0) ? 1 : 0;
      fl = (!st && br) ? 1 : 0;
      chk($sformatf("%s.fwdA[%0d]", nm, k), int'(dfa[k]), mfwd(fen[k], rs, urs));
      chk($sformatf("%s.fwdB[%0d]", nm, k), int'(dfb[k]), mfwd(fen[k], rt, urt));
      chk($sformatf("%s.stall[%0d]", nm, k), int'(dst[k]), st);
      chk($sformatf("%s.bubble[%0d]", nm, k), int'(dbu[k]), st);
      chk($sformatf("%s.flush[%0d]", nm, k), int'(dfl[k]), fl);
      chk($sformatf("%s.scnt[%0d]", nm, k), dsc[k], scnt[k]);
      chk($sformatf("%s.fcnt[%0d]", nm, k), dfc[k], fcnt[k]);
      if (pend[k] > 0) pend[k]--;
      else if (nd > 0) pend[k] = nd - 1;
      if (st != 0 && scnt[k] < cmax[k]) scnt[k]++;
      if (fl != 0 && fcnt[k] < cmax[k]) fcnt[k]++;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(string nm);
    clear_in();
    Clrn = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.rst_stall[%0d]", nm, k), int'(dst[k]), 0);
      chk($sformatf("%s.rst_scnt[%0d]", nm, k), dsc[k], 0);
      chk($sformatf("%s.rst_fcnt[%0d]", nm, k), dfc[k], 0);
    end
    model_reset();
    Clrn = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, ewr, mwr;
    logic urs, urt, br, ew, er, mw, mr;
    logic [1:0] fa, fb;
    logic st, fl;
  } vec_t;

  function automatic vec_t mk(int a, int b, int ua, int ub, int bt,
                              int e_w, int e_r, int e_d, int m_w, int m_r, int m_d,
                              int xa, int xb, int xs, int xf);
    vec_t v;
    v.rs = 5'(a); v.rt = 5'(b); v.urs = 1'(ua); v.urt = 1'(ub); v.br = 1'(bt);
    v.ew = 1'(e_w); v.er = 1'(e_r); v.ewr = 5'(e_d);
    v.mw = 1'(m_w); v.mr = 1'(m_r); v.mwr = 5'(m_d);
    v.fa = 2'(xa); v.fb = 2'(xb); v.st = 1'(xs); v.fl = 1'(xf);
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    //            rs rt ua ub br  ew er ed  mw mr md   fa fb st fl   (forwarding instance)
    tbl[0] = mk(3, 0, 1, 0, 0,  1, 1, 3,  0, 0, 0,   1, 0, 0, 0);
    tbl[1] = mk(0, 5, 0, 1, 0,  1, 0, 5,  0, 0, 0,   0, 0, 1, 0);
    tbl[2] = mk(0, 5, 0, 1, 0,  0, 0, 0,  1, 0, 5,   0, 3, 0, 0);
    tbl[3] = mk(7, 0, 1, 0, 0,  1, 1, 7,  1, 1, 7,   1, 0, 0, 0);
    tbl[4] = mk(0, 0, 1, 1, 0,  1, 1, 0,  1, 1, 0,   0, 0, 0, 0);
    tbl[5] = mk(9, 9, 1, 1, 0,  0, 0, 0,  1, 1, 9,   2, 2, 0, 0);
    tbl[6] = mk(6, 0, 0, 0, 0,  1, 1, 6,  0, 0, 0,   0, 0, 0, 0);
    tbl[7] = mk(1, 2, 1, 1, 1,  1, 1, 3,  1, 1, 4,   0, 0, 0, 1);
    tbl[8] = mk(0, 8, 0, 1, 1,  1, 0, 8,  0, 0, 0,   0, 0, 1, 0);

    clear_in();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    do_reset("reset");

    for (int i = 0; i < 9; i++) begin
      rs = tbl[i].rs; rt = tbl[i].rt; urs = tbl[i].urs; urt = tbl[i].urt; br = tbl[i].br;
      ew = tbl[i].ew; er = tbl[i].er; ewr = tbl[i].ewr;
      mw = tbl[i].mw; mr = tbl[i].mr; mwr = tbl[i].mwr;
      #1;
      chk($sformatf("tbl%0d.fwdA", i), int'(dfa[0]), int'(tbl[i].fa));
      chk($sformatf("tbl%0d.fwdB", i), int'(dfb[0]), int'(tbl[i].fb));
      chk($sformatf("tbl%0d.stall", i), int'(dst[0]), int'(tbl[i].st));
      chk($sformatf("tbl%0d.flush", i), int'(dfl[0]), int'(tbl[i].fl));
      step($sformatf("tbl%0d", i));
    end

    // Load-use then forward from MEM load data
    do_reset("lu");
    clear_in(); ew = 1; er = 0; ewr = 5; rt = 5; urt = 1;
    #1 chk("lu.stall", int'(dst[0]), 1);
    step("lu1");
    clear_in(); mw = 1; mr = 0; mwr = 5; rt = 5; urt = 1;
    #1 chk("lu.fwdB", int'(dfb[0]), 3);
    chk("lu.nostall", int'(dst[0]), 0);
    step("lu2");

    // No-forward: EXE producer stalls 2 cycles, MEM-only producer 1 cycle
    do_reset("nf");
    clear_in(); ew = 1; er = 1; ewr = 4; rs = 4; urs = 1;
    #1 chk("nf.stall1", int'(dst[1]), 1);
    step("nf1");
    clear_in(); mw = 1; mr = 1; mwr = 4; rs = 4; urs = 1;
    #1 chk("nf.stall2", int'(dst[1]), 1);
    step("nf2");
    clear_in(); rs = 4; urs = 1;
    #1 chk("nf.stall3", int'(dst[1]), 0);
    chk("nf.scnt2", dsc[1], 2);
    step("nf3");
    clear_in(); mw = 1; mr = 1; mwr = 4; rs = 4; urs = 1;
    #1 chk("nf.mstall", int'(dst[1]), 1);
    step("nf4");
    clear_in(); rs = 4; urs = 1;
    #1 chk("nf.mdone", int'(dst[1]), 0);
    chk("nf.scnt3", dsc[1], 3);
    step("nf5");

    // Taken branch behind a load-use hazard
    do_reset("br");
    clear_in(); ew = 1; er = 0; ewr = 5; rt = 5; urt = 1; br = 1;
    #1 chk("br.flush0", int'(dfl[0]), 0);
    step("br1");
    clear_in(); mw = 1; mr = 0; mwr = 5; rt = 5; urt = 1; br = 1;
    #1 chk("br.flush1", int'(dfl[0]), 1);
    step("br2");
    clear_in();
    #1 chk("br.fcnt", dfc[0], 1);
    step("br3");

    // Async reset while the no-forward instance sits in its extra stall cycle
    do_reset("ar");
    clear_in(); ew = 1; er = 1; ewr = 4; rs = 4; urs = 1;
    step("ar1");
    clear_in();
    #1 chk("ar.install", int'(dst[1]), 1);
    Clrn = 1'b0;
    #1 chk("ar.stall", int'(dst[1]), 0);
    chk("ar.scnt", dsc[1], 0);
    model_reset();
    Clrn = 1'b1;
    step("ar2");

    // 2-bit counter saturation
    do_reset("sat");
    clear_in(); ew = 1; er = 0; ewr = 5; rt = 5; urt = 1;
    for (int i = 0; i < 5; i++) step("sat");
    clear_in();
    #1 chk("sat.scnt2b", dsc[2], 3);
    chk("sat.scnt16b", dsc[0], 5);
    step("sat_end");

    // Random traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      urs = 1'($urandom); urt = 1'($urandom); br = 1'($urandom_range(0, 3) == 0);
      ew = 1'($urandom); er = 1'($urandom); ewr = 5'($urandom_range(0, 3));
      mw = 1'($urandom); mr = 1'($urandom); mwr = 5'($urandom_range(0, 3));
      if (i == 200) begin
        do_reset("rndrst");
        continue;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
